// File: rtl/id_hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bundle.
//   master: decode/pipeline side, drives ID operand info and stage fires,
//           consumes stall, forwarding selects, stall counter and error flag.
//   slave : the scoreboard itself.
// Signals:
//   id_valid, id_fire, id_rj, id_rkd, id_use_rj, id_use_rkd, id_dest,
//   id_is_load, ex_fire, mem_fire, wb_fire                (master -> slave)
//   stall_id, fwd_sel_rj, fwd_sel_rkd, stall_cnt,
//   err_fire_on_stall                                     (slave -> master)
interface id_hazard_scoreboard_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_fire;
  logic [4:0]       id_rj;
  logic [4:0]       id_rkd;
  logic             id_use_rj;
  logic             id_use_rkd;
  logic [4:0]       id_dest;
  logic             id_is_load;
  logic             ex_fire;
  logic             mem_fire;
  logic             wb_fire;
  logic             stall_id;
  logic [1:0]       fwd_sel_rj;
  logic [1:0]       fwd_sel_rkd;
  logic [CNT_W-1:0] stall_cnt;
  logic             err_fire_on_stall;

  modport master (
    output id_valid, id_fire, id_rj, id_rkd, id_use_rj, id_use_rkd,
           id_dest, id_is_load, ex_fire, mem_fire, wb_fire,
    input  stall_id, fwd_sel_rj, fwd_sel_rkd, stall_cnt, err_fire_on_stall
  );

  modport slave (
    input  id_valid, id_fire, id_rj, id_rkd, id_use_rj, id_use_rkd,
           id_dest, id_is_load, ex_fire, mem_fire, wb_fire,
    output stall_id, fwd_sel_rj, fwd_sel_rkd, stall_cnt, err_fire_on_stall
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard controller. Tracks a shadow pipe of in-flight register
// writers {valid, dest, is_load} in EX/MEM/WB, advanced by the real stage
// fires, and derives load-use stall, per-operand forwarding selects
// (00 regfile, 01 EX, 10 MEM, 11 WB), a saturating stall-cycle counter and a
// sticky "id_fire while stalled" error flag.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   sb    : id_hazard_scoreboard_if.slave (see interface header)
// Parameters:
//   MEM_LOAD_FWD : 1 = load data forwardable from MEM (only load in EX stalls)
//                  0 = load in EX or MEM stalls
//   CNT_W        : stall counter width
module id_hazard_scoreboard #(
  parameter bit MEM_LOAD_FWD = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  id_hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic       vld;
    logic [4:0] dest;
    logic       ld;
  } slot_t;

  localparam int               NUM_OPS = 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             stall;

  // Operand 0 = rj, operand 1 = rkd.
  logic [NUM_OPS-1:0][4:0] op_reg;
  logic [NUM_OPS-1:0]      op_use;
  logic [NUM_OPS-1:0]      haz;
  logic [NUM_OPS-1:0][1:0] sel;

  assign op_reg = {sb.id_rkd, sb.id_rj};
  assign op_use = {sb.id_use_rkd, sb.id_use_rj};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    logic m_ex, m_mem, m_wb;
    // dest==0 never matches, so r0 reads always come from the regfile.
    assign m_ex  = ex_q.vld  && (ex_q.dest  != 5'd0) && (ex_q.dest  == op_reg[g]) && op_use[g];
    assign m_mem = mem_q.vld && (mem_q.dest != 5'd0) && (mem_q.dest == op_reg[g]) && op_use[g];
    assign m_wb  = wb_q.vld  && (wb_q.dest  != 5'd0) && (wb_q.dest  == op_reg[g]) && op_use[g];
    // Youngest producer wins.
    assign sel[g] = m_ex ? 2'b01 : m_mem ? 2'b10 : m_wb ? 2'b11 : 2'b00;
    // Only the youngest match matters: a load shadowed by a younger ALU
    // writer of the same register does not stall.
    assign haz[g] = (m_ex & ex_q.ld) |
                    ((MEM_LOAD_FWD == 1'b0) & ~m_ex & m_mem & mem_q.ld);
  end

  assign stall = sb.id_valid & (|haz);

  assign sb.stall_id          = stall;
  assign sb.fwd_sel_rj        = sel[0];
  assign sb.fwd_sel_rkd       = sel[1];
  assign sb.stall_cnt         = cnt_q;
  assign sb.err_fire_on_stall = err_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    err_d = err_q;
    // All slots shift in parallel from pre-edge values.
    if (sb.id_fire)      ex_d = {1'b1, sb.id_dest, sb.id_is_load};
    else if (sb.ex_fire) ex_d.vld = 1'b0;
    if (sb.ex_fire)       mem_d = ex_q;
    else if (sb.mem_fire) mem_d.vld = 1'b0;
    if (sb.mem_fire)     wb_d = mem_q;
    else if (sb.wb_fire) wb_d.vld = 1'b0;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_ONE;
    // Slot update above is not gated, so a protocol violation stays visible.
    if (sb.id_fire && stall) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.CNT_W(CW)) if1 ();
  id_hazard_scoreboard_if #(.CNT_W(CW)) if0 ();

  // Both variants see identical stimulus.
  assign if0.id_valid   = if1.id_valid;
  assign if0.id_fire    = if1.id_fire;
  assign if0.id_rj      = if1.id_rj;
  assign if0.id_rkd     = if1.id_rkd;
  assign if0.id_use_rj  = if1.id_use_rj;
  assign if0.id_use_rkd = if1.id_use_rkd;
  assign if0.id_dest    = if1.id_dest;
  assign if0.id_is_load = if1.id_is_load;
  assign if0.ex_fire    = if1.ex_fire;
  assign if0.mem_fire   = if1.mem_fire;
  assign if0.wb_fire    = if1.wb_fire;

  id_hazard_scoreboard #(.MEM_LOAD_FWD(1'b1), .CNT_W(CW)) dut1 (.clk(clk), .reset(reset), .sb(if1));
  id_hazard_scoreboard #(.MEM_LOAD_FWD(1'b0), .CNT_W(CW)) dut0 (.clk(clk), .reset(reset), .sb(if0));

  typedef struct {
    logic v, f; logic [4:0] rj; logic urj; logic [4:0] rkd; logic urkd;
    logic [4:0] dst; logic ld; logic xf, mf, wf;
    logic [1:0] sj, sk; logic st1, st0; logic [3:0] c1, c0;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  vec_t expq[$];
  vec_t e;
  int n_chk = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic v, f, input logic [4:0] rj, input logic urj,
                              input logic [4:0] rkd, input logic urkd, input logic [4:0] dst,
                              input logic ld, xf, mf, wf, input logic [1:0] sj, sk,
                              input logic st1, st0, input logic [3:0] c1, c0);
    vec_t t;
    t.v = v; t.f = f; t.rj = rj; t.urj = urj; t.rkd = rkd; t.urkd = urkd;
    t.dst = dst; t.ld = ld; t.xf = xf; t.mf = mf; t.wf = wf;
    t.sj = sj; t.sk = sk; t.st1 = st1; t.st0 = st0; t.c1 = c1; t.c0 = c0;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    if1.id_valid = t.v; if1.id_fire = t.f; if1.id_rj = t.rj; if1.id_use_rj = t.urj;
    if1.id_rkd = t.rkd; if1.id_use_rkd = t.urkd; if1.id_dest = t.dst;
    if1.id_is_load = t.ld; if1.ex_fire = t.xf; if1.mem_fire = t.mf; if1.wb_fire = t.wf;
  endtask

  task automatic idle();
    apply(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
  endtask

  initial begin
    //              v f rj u rkd u dst ld xf mf wf | sj sk st1 st0 c1 c0
    vecs[0]  = mk(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0, 0,0);
    vecs[1]  = mk(1,1, 0,0, 0,0, 5,0, 0,0,0, 0,0,0,0, 0,0); // add r5
    vecs[2]  = mk(1,0, 5,1, 0,0, 0,0, 1,0,0, 1,0,0,0, 0,0); // fwd from EX
    vecs[3]  = mk(1,0, 5,1, 0,0, 0,0, 0,1,0, 2,0,0,0, 0,0); // MEM
    vecs[4]  = mk(1,0, 5,1, 0,0, 0,0, 0,0,1, 3,0,0,0, 0,0); // WB
    vecs[5]  = mk(1,0, 5,1, 0,0, 0,0, 0,0,0, 0,0,0,0, 0,0); // retired
    vecs[6]  = mk(1,1, 0,0, 0,0, 7,1, 0,0,0, 0,0,0,0, 0,0); // load r7
    vecs[7]  = mk(1,0, 0,0, 7,1, 0,0, 1,0,0, 0,1,1,1, 0,0); // load-use, both stall
    vecs[8]  = mk(1,0, 0,0, 7,1, 0,0, 0,0,0, 0,2,0,1, 1,1); // load in MEM
    vecs[9]  = mk(1,0, 0,0, 7,1, 0,0, 0,1,0, 0,2,0,1, 1,2);
    vecs[10] = mk(1,0, 0,0, 7,1, 0,0, 0,0,1, 0,3,0,0, 1,3); // load in WB
    vecs[11] = mk(1,1, 0,0, 0,0, 3,1, 0,0,0, 0,0,0,0, 1,3); // load r3
    vecs[12] = mk(1,1, 0,0, 0,0, 3,0, 1,0,0, 0,0,0,0, 1,3); // addi r3
    vecs[13] = mk(1,0, 3,1, 0,1, 0,0, 0,0,0, 1,0,0,0, 1,3); // shadowed load; r0
    vecs[14] = mk(1,1, 0,1, 0,0, 0,0, 1,1,0, 0,0,0,0, 1,3); // dest=0 writer
    vecs[15] = mk(1,0, 3,0, 3,1, 0,0, 1,1,1, 0,2,0,0, 1,3); // use bit off on rj
    vecs[16] = mk(1,0, 0,0, 3,1, 0,0, 1,1,1, 0,3,0,0, 1,3);
    vecs[17] = mk(1,1, 0,0, 3,1, 9,1, 0,0,0, 0,0,0,0, 1,3); // load r9
    vecs[18] = mk(0,0, 9,1, 0,0, 0,0, 0,0,0, 1,0,0,0, 1,3); // no stall w/o id_valid
    vecs[19] = mk(1,0, 9,1, 9,1, 0,0, 1,0,0, 1,1,1,1, 1,3);
    vecs[20] = mk(1,0, 9,1, 0,0, 0,0, 0,0,0, 2,0,0,1, 2,4);
    vecs[21] = mk(0,0, 9,1, 0,0, 0,0, 0,1,1, 2,0,0,0, 2,5);
    vecs[22] = mk(1,0, 9,1, 0,0, 0,0, 0,0,1, 3,0,0,0, 2,5);

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset sel_rj",  32'(if1.fwd_sel_rj), 0);
    chk("reset sel_rkd", 32'(if1.fwd_sel_rkd), 0);
    chk("reset stall",   32'(if1.stall_id), 0);
    chk("reset cnt",     32'(if1.stall_cnt), 0);
    chk("reset err",     32'(if1.err_fire_on_stall), 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      expq.push_back(vecs[i]);
      #1;
      e = expq.pop_front();
      chk($sformatf("r%0d sel_rj", i),  32'(if1.fwd_sel_rj),  32'(e.sj));
      chk($sformatf("r%0d sel_rkd", i), 32'(if1.fwd_sel_rkd), 32'(e.sk));
      chk($sformatf("r%0d f0 sel_rkd", i), 32'(if0.fwd_sel_rkd), 32'(e.sk));
      chk($sformatf("r%0d stall f1", i), 32'(if1.stall_id), 32'(e.st1));
      chk($sformatf("r%0d stall f0", i), 32'(if0.stall_id), 32'(e.st0));
      chk($sformatf("r%0d cnt f1", i), 32'(if1.stall_cnt), 32'(e.c1));
      chk($sformatf("r%0d cnt f0", i), 32'(if0.stall_cnt), 32'(e.c0));
    end
    chk("tbl err f1", 32'(if1.err_fire_on_stall), 0);
    chk("tbl err f0", 32'(if0.err_fire_on_stall), 0);

    // id_fire while stalled sets the sticky error.
    @(negedge clk); idle(); if1.id_fire = 1'b1; if1.id_dest = 5'd4; if1.id_is_load = 1'b1;
    @(negedge clk); idle(); if1.id_valid = 1'b1; if1.id_fire = 1'b1;
    if1.id_rj = 5'd4; if1.id_use_rj = 1'b1;
    #1;
    chk("err stall f1", 32'(if1.stall_id), 1);
    chk("err pre f1", 32'(if1.err_fire_on_stall), 0);
    @(negedge clk); idle(); #1;
    chk("err set f1", 32'(if1.err_fire_on_stall), 1);
    chk("err set f0", 32'(if0.err_fire_on_stall), 1);
    repeat (2) @(negedge clk);
    #1;
    chk("err sticky f1", 32'(if1.err_fire_on_stall), 1);

    // Reset with every fire active discards all in-flight writers.
    @(negedge clk); idle(); if1.id_fire = 1'b1; if1.id_dest = 5'd6;
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1,1, 6,1, 8,1, 8,0, 1,1,1, 0,0,0,0, 0,0));
    #1;
    chk("pre-rst sel_rj", 32'(if1.fwd_sel_rj), 1);
    @(negedge clk);
    reset = 1'b0;
    apply(mk(1,0, 6,1, 8,1, 0,0, 0,0,0, 0,0,0,0, 0,0));
    #1;
    chk("rst sel_rj",  32'(if1.fwd_sel_rj), 0);
    chk("rst sel_rkd", 32'(if1.fwd_sel_rkd), 0);
    chk("rst stall",   32'(if1.stall_id), 0);
    chk("rst err f1",  32'(if1.err_fire_on_stall), 0);
    chk("rst err f0",  32'(if0.err_fire_on_stall), 0);
    chk("rst cnt f0",  32'(if0.stall_cnt), 0);

    // Hold a load-use stall for 2^CW+3 cycles; counter saturates.
    @(negedge clk); idle(); if1.id_fire = 1'b1; if1.id_dest = 5'd10; if1.id_is_load = 1'b1;
    @(negedge clk); idle(); if1.id_valid = 1'b1; if1.id_rj = 5'd10; if1.id_use_rj = 1'b1;
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      #1;
      chk($sformatf("sat%0d f1", k), 32'(if1.stall_cnt), (k > 15) ? 15 : k);
      chk($sformatf("sat%0d f0", k), 32'(if0.stall_cnt), (k > 15) ? 15 : k);
      @(negedge clk);
    end
    #1;
    chk("sat end f1", 32'(if1.stall_cnt), 15);
    chk("sat stall", 32'(if1.stall_id), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Sequential hazard controller for the decode stage.
- Keeps a shadow pipeline of in-flight register writers {valid, dest, is_load} for the EX, MEM and WB slots. The slots advance on the real stage handshakes.
- From that shadow state it drives the decode-stage stall (load-use), per-operand forwarding-source selects, a saturating stall-cycle counter and a sticky protocol-error flag.
- Sits beside the decode stage. It replaces the ad-hoc forwarding/stall compare logic so that the decode stage only consumes the select and stall outputs.

Parameters:
- MEM_LOAD_FWD, 1, 1: load data can be forwarded from MEM, so only a load in EX stalls. 0: a load in EX or MEM stalls; forward only from WB.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_fire  in  1  decode-to-EX transfer this cycle (ID_to_EX_valid & EX_allow_in)
- id_rj  in  5  register index of source operand 1
- id_rkd  in  5  register index of source operand 2
- id_use_rj  in  1  instruction reads rj
- id_use_rkd  in  1  instruction reads rkd
- id_dest  in  5  destination register; 0 when the instruction does not write
- id_is_load  in  1  instruction is a load
- ex_fire  in  1  EX-to-MEM transfer this cycle
- mem_fire  in  1  MEM-to-WB transfer this cycle
- wb_fire  in  1  WB retires its instruction this cycle
- stall_id  out  1  decode must not advance
- fwd_sel_rj  out  2  source for rj: 00 regfile, 01 EX, 10 MEM, 11 WB
- fwd_sel_rkd  out  2  same encoding, for rkd
- stall_cnt  out  CNT_W  number of cycles with stall_id=1
- err_fire_on_stall  out  1  sticky flag: id_fire was seen while stall_id=1

Behaviour:
- Reset (synchronous):
  - all three slots valid=0, dest=0, is_load=0;
  - stall_cnt=0; err_fire_on_stall=0.
  - Consequence: stall_id=0 and both selects=00 in the cycle after reset.
- Slot update, every posedge, all slots in parallel using pre-edge values:
  - EX slot: takes {1, id_dest, id_is_load} if id_fire; else clears valid if ex_fire; else holds.
  - MEM slot: takes the EX slot if ex_fire; else clears valid if mem_fire; else holds.
  - WB slot: takes the MEM slot if mem_fire; else clears valid if wb_fire; else holds.
  - A slot whose dest=0 is kept but never matches.
- Simultaneous events:
  - id_fire & ex_fire: EX gets the new instruction and MEM gets the old EX slot.
  - All fires in one cycle: the whole shadow pipe shifts by one.
- Match rule: slot s matches operand r when s.valid & s.dest!=0 & s.dest==r & the operand's use bit is set. Register 0 never matches.
- Forwarding select: combinational from the current slots, youngest match wins (EX > MEM > WB, else 00).
- Stall, combinational: stall_id = id_valid & (hazard_rj | hazard_rkd).
  - An operand's hazard is set when its youngest match is a load in EX.
  - It is also set when MEM_LOAD_FWD=0 and the youngest match is a load in MEM.
  - An older load shadowed by a younger non-load match does not stall.
  - Selects stay valid during a stall, so the consumer may ignore them.
- Latency: a producer issued at edge N is visible in the selects from cycle N+1.
- stall_cnt:
  - increments at each edge where stall_id=1;
  - saturates at all-ones (no wrap);
  - holds otherwise.
- err_fire_on_stall: set at an edge where id_fire & stall_id; cleared only by reset.
  - The slot update still happens, so the error is observable but not masked.
- Reset mid-operation: all in-flight slots are discarded regardless of pending fires.

Test Plan:
- Reset, then idle: selects 00, stall_id=0, stall_cnt=0.
- Back-to-back ALU dependency: add writes r5 (id_fire); next cycle id_rj=5, id_use_rj=1 -> fwd_sel_rj=01, stall_id=0.
- Advance the pipe (ex_fire, mem_fire each cycle) -> fwd_sel_rj goes 10, then 11, then 00 after wb_fire.
- Load r7 in EX, consumer id_rkd=7 with id_valid=1, hold 1 cycle:
  - MEM_LOAD_FWD=1: stall_id=1 for exactly that cycle; after ex_fire, stall_id=0 and fwd_sel_rkd=10; stall_cnt=1.
  - MEM_LOAD_FWD=0: stall persists until the load reaches WB, then fwd_sel_rkd=11.
- Shadowing: load r3 in MEM and addi r3 in EX, consumer reads r3 -> fwd_sel_rj=01, stall_id=0. A consumer with dest=0 and reading r0 gives no match.
- Force stall_id for 2^CNT_W+3 cycles (CNT_W overridden to 4 at the bench) -> stall_cnt sticks at 4'hF.
- Protocol and reset checks:
  - Pulse id_fire while stalled -> err_fire_on_stall=1 until reset.
  - Reset asserted with all fires active -> slots cleared and flag 0 at the next cycle.
